sync_arb_mux: RTL and testbench

Parametrised, registered N-to-1 datapath multiplexer with per-channel valid/ready handshakes, a one-entry output register, and two selection modes: directed (external select) and round-robin (fair arbitration). It is the successor to the team's combinational 2:1 and 4:1 32-bit muxes. It sits between multiple producers (ALU result, memory read data, shifter, immediate path) and a single pipelined consumer such as register-file writeback, where a plain combinational mux cannot absorb backpressure or share a port fairly.

---
 rtl/sync_arb_mux_if.sv | 66 ++++++
 rtl/sync_arb_mux.sv | 132 +++++++++++++
 tb/tb_sync_arb_mux.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_arb_mux_if.sv
// -----------------------------------------------------------------------------
// sync_arb_mux_if
//   Bundle of the select, producer-side and consumer-side handshake signals of
//   sync_arb_mux.
//
//   Parameters
//     WIDTH  data width in bits
//     N      number of producer channels
//     SEL_W  select / source-index width, derived from N
//
//   Signals
//     mode       0 = directed (use sel), 1 = round-robin
//     sel        channel index used in directed mode
//     in_valid   per-channel data valid
//     in_ready   per-channel accept (combinational)
//     in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//     out_valid  output register holds a word
//     out_ready  consumer accepts the word
//     out_data   registered data
//     out_src    index of the channel that produced out_data
//
//   Modports
//     master  the environment: producers, select logic and consumer
//     slave   the mux itself
// -----------------------------------------------------------------------------
interface sync_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
);

  logic                 mode;
  logic [SEL_W-1:0]     sel;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_src;

  modport master (
    output mode,
    output sel,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_src
  );

  modport slave (
    input  mode,
    input  sel,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_src
  );

endinterface : sync_arb_mux_if

// File: rtl/sync_arb_mux.sv
// -----------------------------------------------------------------------------
// sync_arb_mux
//   Registered N-to-1 datapath multiplexer with per-channel valid/ready
//   handshakes and a one-entry output register. The granted channel is either
//   chosen by an external select (directed mode) or by a rotating-priority
//   round-robin arbiter (round-robin mode). Sustains one word per cycle when
//   the consumer keeps out_ready high.
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    sync_arb_mux_if.slave (select, producer and consumer handshakes)
// -----------------------------------------------------------------------------
module sync_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  sync_arb_mux_if.slave bus
);

  // Output register and round-robin pointer.
  logic                out_valid_q;
  logic [WIDTH-1:0]    out_data_q;
  logic [SEL_W-1:0]    out_src_q;
  logic [SEL_W-1:0]    ptr_q;

  // Grant evaluation.
  logic                grant_any;
  logic [SEL_W-1:0]    grant_idx;
  logic [N-1:0]        grant;
  logic [WIDTH-1:0]    grant_data;
  logic                free;
  logic                xfer;

  // Round-robin search halves: channels at or above ptr win over channels
  // below it, and within each half the lowest index wins.
  logic                hit_hi;
  logic                hit_lo;
  logic [SEL_W-1:0]    idx_hi;
  logic [SEL_W-1:0]    idx_lo;

  // The slot can take a new word if it is empty or is being drained this cycle.
  assign free = !out_valid_q || bus.out_ready;

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : grant_logic
    hit_hi    = 1'b0;
    hit_lo    = 1'b0;
    idx_hi    = '0;
    idx_lo    = '0;
    grant_any = 1'b0;
    grant_idx = '0;

    // Descending scan so the last assignment in each half is its lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        if (SEL_W'(i) >= ptr_q) begin
          hit_hi = 1'b1;
          idx_hi = SEL_W'(i);
        end else begin
          hit_lo = 1'b1;
          idx_lo = SEL_W'(i);
        end
      end
    end

    if (!bus.mode) begin
      // Directed: the select alone decides; channel validity is irrelevant.
      if (int'(bus.sel) < N) begin
        grant_any = 1'b1;
        grant_idx = bus.sel;
      end
    end else if (hit_hi) begin
      grant_any = 1'b1;
      grant_idx = idx_hi;
    end else if (hit_lo) begin
      grant_any = 1'b1;
      grant_idx = idx_lo;
    end
  end

  always_comb begin : grant_decode
    grant      = '0;
    grant_data = '0;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (SEL_W'(i) == grant_idx) begin
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // At most one bit of grant is set, so at most one in_ready is high.
  assign bus.in_ready = grant & {N{free}};
  assign xfer         = |(bus.in_valid & bus.in_ready);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      if (xfer) begin
        // A transfer also covers the simultaneous-drain case: the new word
        // simply overwrites the one being consumed.
        out_valid_q <= 1'b1;
        out_data_q  <= grant_data;
        out_src_q   <= grant_idx;
        if (bus.mode) begin
          ptr_q <= (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
      end else if (bus.out_ready) begin
        // Drain without refill; data and source keep their last values.
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule : sync_arb_mux

// File: tb/tb_sync_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_sync_arb_mux
//   Self-checking bench for sync_arb_mux. dut4 is the N=4, WIDTH=32 instance;
//   expected words are queued when a producer is driven and compared by a
//   monitor after the edge on which dut4 completes a handshake. dut5 (N=5,
//   WIDTH=8) covers select values >= N (not representable in 2 bits) and
//   round-robin wrap with a non-power-of-two channel count.
// -----------------------------------------------------------------------------
module tb_sync_arb_mux;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_arb_mux_if #(.WIDTH(32), .N(4)) bus4 ();
  sync_arb_mux_if #(.WIDTH(8),  .N(5)) bus5 ();

  sync_arb_mux #(.WIDTH(32), .N(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  sync_arb_mux #(.WIDTH(8), .N(5)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  src;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: a handshake seen at a rising edge must show up as the
  // next queued word half a cycle later.
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    if (!reset && ((bus4.in_valid & bus4.in_ready) != 4'b0000)) begin
      @(negedge clk);
      if (!reset) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_word: got data=%h src=%0d, expected no transfer",
                   bus4.out_data, bus4.out_src);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus4.out_valid !== 1'b1 || bus4.out_data !== mon_e.data ||
              bus4.out_src !== mon_e.src) begin
            n_fail++;
            $display("FAIL sb_word: got valid=%b data=%h src=%0d, expected valid=1 data=%h src=%0d",
                     bus4.out_valid, bus4.out_data, bus4.out_src, mon_e.data, mon_e.src);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic load_default_data();
    for (int i = 0; i < 4; i++) bus4.in_data[i*32 +: 32] = 32'hA0 + 32'(i);
    for (int i = 0; i < 5; i++) bus5.in_data[i*8 +: 8]   = 8'h50 + 8'(i);
  endtask

  task automatic push_exp(input logic [31:0] data, input logic [1:0] src);
    exp_t e;
    e.data = data;
    e.src  = src;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Tests (each starts and ends just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset          = 1'b1;
    bus4.mode      = 1'b1;
    bus4.sel       = 2'd2;
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    bus5.mode      = 1'b0;
    bus5.sel       = 3'd1;
    bus5.in_valid  = 5'b11111;
    bus5.out_ready = 1'b1;
    load_default_data();
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h0 || bus4.out_src !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got valid=%b data=%h src=%0d, expected 0/0/0",
                 bus4.out_valid, bus4.out_data, bus4.out_src);
      end
    end
    bus4.in_valid = 4'b0000;
    bus5.in_valid = 5'b00000;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h0 || bus4.out_src !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_first_cycle: got valid=%b data=%h src=%0d, expected 0/0/0",
               bus4.out_valid, bus4.out_data, bus4.out_src);
    end
    // Round-robin after reset: lowest valid index wins.
    bus4.mode     = 1'b1;
    bus4.in_valid = 4'b0110;
    push_exp(32'hA1, 2'd1);
    #1;
    n_checks++;
    if (bus4.in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_first_grant: got in_ready=%b, expected 0010", bus4.in_ready);
    end
    @(negedge clk);
    bus4.in_valid = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (bus4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drain: got out_valid=%b, expected 0", bus4.out_valid);
    end
  endtask

  task automatic test_directed();
    bus4.mode     = 1'b0;
    bus4.sel      = 2'd2;
    bus4.in_valid = 4'b1111;
    push_exp(32'h0000_00A2, 2'd2);
    #1;
    n_checks++;
    if (bus4.in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL directed_ready: got in_ready=%b, expected 0100", bus4.in_ready);
    end
    @(negedge clk);
    // Grant ignores validity in directed mode.
    bus4.in_valid = 4'b0000;
    bus4.sel      = 2'd0;
    #1;
    n_checks++;
    if (bus4.in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL directed_grant_no_valid: got in_ready=%b, expected 0001", bus4.in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL directed_drain: got out_valid=%b, expected 0", bus4.out_valid);
    end
  endtask

  task automatic test_sel_out_of_range();
    bus5.mode     = 1'b0;
    bus5.in_valid = 5'b11111;
    for (int s = 5; s < 8; s++) begin
      bus5.sel = 3'(s);
      #1;
      n_checks++;
      if (bus5.in_ready !== 5'b00000) begin
        n_fail++;
        $display("FAIL sel_oor_ready: sel=%0d got in_ready=%b, expected 00000", s, bus5.in_ready);
      end
      @(negedge clk);
      n_checks++;
      if (bus5.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL sel_oor_valid: sel=%0d got out_valid=%b, expected 0", s, bus5.out_valid);
      end
    end
    bus5.in_valid = 5'b00000;
  endtask

  task automatic test_rr_fairness();
    logic [3:0] exp_rdy;
    // Only channel 3 valid from ptr=2: grant 3, pointer wraps to 0.
    bus4.mode     = 1'b1;
    bus4.in_valid = 4'b1000;
    push_exp(32'hA3, 2'd3);
    #1;
    n_checks++;
    if (bus4.in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL rr_wrap_ready: got in_ready=%b, expected 1000", bus4.in_ready);
    end
    @(negedge clk);
    bus4.in_valid = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      push_exp(32'hA0 + 32'(k % 4), 2'(k % 4));
      exp_rdy = 4'b0001 << (k % 4);
      #1;
      n_checks++;
      if (bus4.in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rr_all_ready: step %0d got in_ready=%b, expected %b",
                 k, bus4.in_ready, exp_rdy);
      end
      @(negedge clk);
    end
    bus4.in_valid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_rr_non_pow2();
    logic [4:0] exp_rdy;
    bus5.mode     = 1'b1;
    bus5.in_valid = 5'b11111;
    for (int k = 0; k < 10; k++) begin
      exp_rdy = 5'b00001 << (k % 5);
      #1;
      n_checks++;
      if (bus5.in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rr5_ready: step %0d got in_ready=%b, expected %b", k, bus5.in_ready, exp_rdy);
      end
      @(negedge clk);
      n_checks++;
      if (bus5.out_valid !== 1'b1 || bus5.out_src !== 3'(k % 5) ||
          bus5.out_data !== 8'h50 + 8'(k % 5)) begin
        n_fail++;
        $display("FAIL rr5_word: step %0d got valid=%b data=%h src=%0d, expected valid=1 data=%h src=%0d",
                 k, bus5.out_valid, bus5.out_data, bus5.out_src, 8'h50 + 8'(k % 5), k % 5);
      end
    end
    bus5.in_valid = 5'b00000;
    @(negedge clk);
  endtask

  task automatic test_rr_sparse();
    logic [1:0] src;
    // ptr is 1 here; channels 0 and 3 alternate starting with 3.
    bus4.mode     = 1'b1;
    bus4.in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      src = (k % 2 == 0) ? 2'd3 : 2'd0;
      push_exp(32'hA0 + 32'(src), src);
      #1;
      n_checks++;
      if (bus4.in_ready !== (4'b0001 << src)) begin
        n_fail++;
        $display("FAIL rr_sparse_ready: step %0d got in_ready=%b, expected grant to %0d",
                 k, bus4.in_ready, src);
      end
      @(negedge clk);
    end
    bus4.in_valid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus4.mode = 1'b0;
    bus4.sel  = 2'd1;
    bus4.in_data[1*32 +: 32] = 32'h0000_1234;
    bus4.in_valid = 4'b0010;
    push_exp(32'h0000_1234, 2'd1);
    @(negedge clk);
    bus4.out_ready = 1'b0;
    bus4.sel       = 2'd2;
    bus4.in_data[2*32 +: 32] = 32'h0000_5678;
    bus4.in_valid  = 4'b0110;
    for (int r = 0; r < 3; r++) begin
      #1;
      n_checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_data !== 32'h0000_1234 ||
          bus4.out_src !== 2'd1 || bus4.in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL backpressure_hold: cycle %0d got valid=%b data=%h src=%0d in_ready=%b, expected 1/00001234/1/0000",
                 r, bus4.out_valid, bus4.out_data, bus4.out_src, bus4.in_ready);
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus4.out_data !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL backpressure_end: got data=%h, expected 00001234", bus4.out_data);
    end
    // Release: the held word drains on the same edge that takes the next one.
    bus4.out_ready = 1'b1;
    push_exp(32'h0000_5678, 2'd2);
    #1;
    n_checks++;
    if (bus4.in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL backpressure_release: got in_ready=%b, expected 0100", bus4.in_ready);
    end
    @(negedge clk);
    bus4.in_valid = 4'b0000;
    load_default_data();
    @(negedge clk);
  endtask

  task automatic test_mode_switch();
    bus4.mode     = 1'b0;
    bus4.sel      = 2'd3;
    bus4.in_valid = 4'b1000;
    push_exp(32'hA3, 2'd3);
    @(negedge clk);
    bus4.out_ready = 1'b0;
    bus4.mode      = 1'b1;
    bus4.sel       = 2'd0;
    bus4.in_valid  = 4'b0001;
    for (int r = 0; r < 2; r++) begin
      #1;
      n_checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_data !== 32'hA3 ||
          bus4.out_src !== 2'd3 || bus4.in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL mode_switch_hold: cycle %0d got valid=%b data=%h src=%0d in_ready=%b, expected 1/000000a3/3/0000",
                 r, bus4.out_valid, bus4.out_data, bus4.out_src, bus4.in_ready);
      end
      @(negedge clk);
    end
    bus4.out_ready = 1'b1;
    push_exp(32'hA0, 2'd0);
    #1;
    n_checks++;
    if (bus4.in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mode_switch_grant: got in_ready=%b, expected 0001", bus4.in_ready);
    end
    @(negedge clk);
    bus4.in_valid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bus4.mode     = 1'b0;
    bus4.sel      = 2'd1;
    bus4.in_valid = 4'b0010;
    push_exp(32'hA1, 2'd1);
    @(negedge clk);
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 4'b0000;
    #2;
    n_checks++;
    if (bus4.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_pre: got out_valid=%b, expected 1", bus4.out_valid);
    end
    // Assert in the low phase; outputs must clear before the next rising edge.
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h0 || bus4.out_src !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset_clear: got valid=%b data=%h src=%0d, expected 0/0/0",
               bus4.out_valid, bus4.out_data, bus4.out_src);
    end
    @(negedge clk);
    reset          = 1'b0;
    bus4.out_ready = 1'b1;
    bus4.mode      = 1'b1;
    bus4.in_valid  = 4'b1100;
    push_exp(32'hA2, 2'd2);
    #1;
    n_checks++;
    if (bus4.in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL async_reset_ptr: got in_ready=%b, expected 0100", bus4.in_ready);
    end
    @(negedge clk);
    bus4.in_valid = 4'b0000;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    test_reset();
    test_directed();
    test_sel_out_of_range();
    test_rr_fairness();
    test_rr_non_pow2();
    test_rr_sparse();
    test_back_to_back();
    test_mode_switch();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d unconsumed expected words, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_arb_mux
